hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard and forwarding controller for the X (execute) stage of the RV32 core.
//  Tracks destinations held in the M and W stages and selects operand forwarding sources.
//  Stalls X on load-use hazards and on outstanding memory loads.
//  Aborts a load whose acknowledge exceeds TIMEOUT cycles.
// PARAMETERS
//  TIMEOUT  16  max M-stage cycles a load waits for mem_ack; legal range 2..255
// PORTS
//  clk        in   1  core clock
//  reset_n    in   1  asynchronous active-low reset
//  x_v        in   1  valid instruction in X
//  x_rs1      in   5  X source 1 index
//  x_rs1_v    in   1  X reads rs1
//  x_rs2      in   5  X source 2 index
//  x_rs2_v    in   1  X reads rs2
//  x_rd       in   5  X destination index
//  x_rd_v     in   1  X writes rd
//  x_load     in   1  X is a LOAD (result available only after mem_ack)
//  mem_ack    in   1  load data returned this cycle for the load held in M
//  hazard_x   out  1  stall X; combinational
//  fwd_rs1    out  2  rs1 source: 00 regfile, 01 M result, 10 W result
//  fwd_rs2    out  2  rs2 source; same encoding as fwd_rs1
//  w_v        out  1  W-stage register write enable
//  w_rd       out  5  W-stage destination index
//  err_o      out  1  one-cycle pulse: load aborted on timeout
// BEHAVIOUR
//  - Reset (async, reset_n=0): m_v, w_v, err_o, wait_cnt cleared; state=RUN; w_rd=0.
//    hazard_x, fwd_rs1 and fwd_rs2 therefore read 0 while in reset.
//  - Register index 0 is never a destination: x_rd_v qualified with (x_rd!=0).
//  - M stage: m_v, m_rd, m_load. W stage: w_v, w_rd. Single-cycle ops enter W one cycle after M.
//  - mem_stall = m_v & m_load & !mem_ack & state==LD_WAIT-eligible.
//  - load_use = x_v & M holds a valid load & an X source (rsN_v, rsN==m_rd) matches.
//  - hazard_x = mem_stall | load_use.
//  - M update:
//    - mem_stall: hold M.
//    - load_use without mem_stall: load advances to W and a bubble enters M.
//    - Otherwise: M <= X, with m_v = x_v & x_rd_v.
//  - W update: w_v <= M advancing & m_v; w_rd <= m_rd. M never advancing gives w_v=0 next cycle.
//  - Forwarding per source:
//    - M match with a non-load in M -> 01.
//    - Else W match -> 10.
//    - Else 00.
//    - M has priority over W. Load data is never forwarded from M.
//  - FSM (2 bits):
//    - RUN: M holds no waiting load. Load enters M without same-cycle ack -> LD_WAIT.
//    - LD_WAIT: wait_cnt increments each cycle without ack.
//      - mem_ack -> RUN; load moves to W and wait_cnt is cleared.
//      - wait_cnt==TIMEOUT-1 and !mem_ack -> ABORT; M is squashed (m_v=0, no W write).
//    - ABORT: err_o=1 for exactly this cycle; hazard_x from mem_stall is 0 -> RUN.
//  - Load latency: mem_ack in the load's first M cycle gives zero mem_stall cycles.
//  - A dependent instruction right behind a load always stalls >=1 cycle, then gets fwd=10.
//  - Simultaneous mem_ack and wait_cnt==TIMEOUT-1: ack wins, no abort.
//  - wait_cnt width = $clog2(TIMEOUT); it saturates and never wraps.
//  - Reset mid-LD_WAIT: outstanding load discarded; no err_o pulse.
// CONFIGURATION
//  HAZARD_CTRL_FWD_EN
//  - Defined: forwarding as above.
//  - Undefined: fwd_rs1 and fwd_rs2 tied to 00.
//    - hazard_x additionally asserts when any valid X source matches a valid M or W destination.
//    - Dependants wait until the producer has left W.
// TESTING
//  1 reset_n low while in LD_WAIT -> hazard_x=0, w_v=0, err_o=0, state RUN after release
//  2 ADD x5 ; ADD x7,x5,x1 back-to-back -> fwd_rs1=01, hazard_x=0; one gap -> fwd_rs1=10
//  3 LW x6 (ack 1st cycle) ; ADD x8,x6,x6 -> hazard_x=1 for 1 cycle, then fwd_rs1=fwd_rs2=10
//  4 LW x6, mem_ack 3 cycles late, independent ADD behind -> hazard_x=1 exactly 3 cycles
//  5 TIMEOUT=4, LW never acked -> err_o=1 in 5th cycle after M entry, w_v=0, hazard_x drops
//  6 ADD x0 ; ADD x9,x0,x0 -> fwd=00, no stall; with FWD_EN undefined, ADD x5 ; use x5 -> 2 stall cycles

Source files
------------

// File: rtl/hazard_ctrl.sv
// X-stage hazard, forwarding and load-timeout controller for the RV32 pipeline.
// Define HAZARD_CTRL_FWD_EN to forward from M/W; otherwise dependants stall until the producer leaves W.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       x_v,
  input  logic [4:0] x_rs1,
  input  logic       x_rs1_v,
  input  logic [4:0] x_rs2,
  input  logic       x_rs2_v,
  input  logic [4:0] x_rd,
  input  logic       x_rd_v,
  input  logic       x_load,
  input  logic       mem_ack,
  output logic       hazard_x,
  output logic [1:0] fwd_rs1,
  output logic [1:0] fwd_rs2,
  output logic       w_v,
  output logic [4:0] w_rd,
  output logic       err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_WAIT = 2'd1,
    ABORT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic            m_v_q, m_v_d;
  logic [4:0]      m_rd_q, m_rd_d;
  logic            m_load_q, m_load_d;
  logic            w_v_q, w_v_d;
  logic [4:0]      w_rd_q, w_rd_d;

  logic mem_stall, load_use, dep_stall, abort;
  logic rs1_m, rs2_m, rs1_w, rs2_w;

  // Source matches against valid M/W destinations; x0 never becomes a valid destination.
  assign rs1_m = x_rs1_v & m_v_q & (x_rs1 == m_rd_q);
  assign rs2_m = x_rs2_v & m_v_q & (x_rs2 == m_rd_q);
  assign rs1_w = x_rs1_v & w_v_q & (x_rs1 == w_rd_q);
  assign rs2_w = x_rs2_v & w_v_q & (x_rs2 == w_rd_q);

  assign mem_stall = m_v_q & m_load_q & ~mem_ack & (state_q != ABORT);
  assign load_use  = x_v & m_load_q & (rs1_m | rs2_m);
  assign hazard_x  = mem_stall | load_use | dep_stall;

`ifdef HAZARD_CTRL_FWD_EN
  always_comb begin
    dep_stall = 1'b0;
    fwd_rs1   = (rs1_m & ~m_load_q) ? 2'b01 : (rs1_w ? 2'b10 : 2'b00);
    fwd_rs2   = (rs2_m & ~m_load_q) ? 2'b01 : (rs2_w ? 2'b10 : 2'b00);
  end
`else
  always_comb begin
    dep_stall = x_v & (rs1_m | rs2_m | rs1_w | rs2_w);
    fwd_rs1   = 2'b00;
    fwd_rs2   = 2'b00;
  end
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = 1'b0;
    abort      = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = LD_WAIT;
          wait_cnt_d = CW'(1);
        end
      end
      LD_WAIT: begin
        if (!mem_stall) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d    = ABORT;
          wait_cnt_d = '0;
          err_d      = 1'b1;
          abort      = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ABORT:   state_d = RUN;
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    m_v_d    = m_v_q;
    m_rd_d   = m_rd_q;
    m_load_d = m_load_q;
    if (abort) begin
      m_v_d = 1'b0;
    end else if (mem_stall) begin
      m_v_d = m_v_q;
    end else if (hazard_x) begin
      // Producer drains towards W while a bubble fills M.
      m_v_d = 1'b0;
    end else begin
      m_v_d    = x_v & x_rd_v & (x_rd != 5'd0);
      m_rd_d   = x_rd;
      m_load_d = x_load;
    end
    w_v_d  = m_v_q & ~mem_stall;
    w_rd_d = m_rd_q;
  end

  // NOTE: asynchronous reset in the sensitivity list; state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      m_v_q      <= 1'b0;
      m_rd_q     <= 5'd0;
      m_load_q   <= 1'b0;
      w_v_q      <= 1'b0;
      w_rd_q     <= 5'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      m_v_q      <= m_v_d;
      m_rd_q     <= m_rd_d;
      m_load_q   <= m_load_d;
      w_v_q      <= w_v_d;
      w_rd_q     <= w_rd_d;
    end
  end

  assign w_v   = w_v_q;
  assign w_rd  = w_rd_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: an age-based pipeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef HAZARD_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       x_v = 1'b0, x_rs1_v = 1'b0, x_rs2_v = 1'b0, x_rd_v = 1'b0, x_load = 1'b0;
  logic [4:0] x_rs1 = '0, x_rs2 = '0, x_rd = '0;
  logic       mem_ack = 1'b0;
  logic       hazard_x, w_v, err_o;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic [4:0] w_rd;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  hazard_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .x_v(x_v), .x_rs1(x_rs1), .x_rs1_v(x_rs1_v), .x_rs2(x_rs2), .x_rs2_v(x_rs2_v),
    .x_rd(x_rd), .x_rd_v(x_rd_v), .x_load(x_load), .mem_ack(mem_ack),
    .hazard_x(hazard_x), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .w_v(w_v), .w_rd(w_rd), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction in M and how many cycles it has waited, plus the W slot.
  logic       mdl_mv = 1'b0, mdl_mload = 1'b0, mdl_wv = 1'b0, mdl_err = 1'b0;
  logic [4:0] mdl_mrd = '0, mdl_wrd = '0;
  int         mdl_age = 0;

  function automatic bit in_m(input logic v, input logic [4:0] rs);
    return v && mdl_mv && (mdl_mrd == rs);
  endfunction

  function automatic bit in_w(input logic v, input logic [4:0] rs);
    return v && mdl_wv && (mdl_wrd == rs);
  endfunction

  function automatic bit mdl_stall();
    return mdl_mv && mdl_mload && !mem_ack;
  endfunction

  function automatic bit mdl_hazard();
    bit lu, raw;
    lu  = x_v && mdl_mload && (in_m(x_rs1_v, x_rs1) || in_m(x_rs2_v, x_rs2));
    raw = x_v && (in_m(x_rs1_v, x_rs1) || in_m(x_rs2_v, x_rs2) ||
                  in_w(x_rs1_v, x_rs1) || in_w(x_rs2_v, x_rs2));
    return mdl_stall() || lu || (!FWD && raw);
  endfunction

  function automatic logic [1:0] mdl_fwd(input logic v, input logic [4:0] rs);
    if (!FWD) return 2'b00;
    if (in_m(v, rs) && !mdl_mload) return 2'b01;
    if (in_w(v, rs)) return 2'b10;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_mv <= 1'b0; mdl_mload <= 1'b0; mdl_mrd <= '0;
      mdl_wv <= 1'b0; mdl_wrd <= '0; mdl_err <= 1'b0; mdl_age <= 0;
    end else if (mdl_stall()) begin
      mdl_wv <= 1'b0;
      if (mdl_age + 1 >= int'(TB_TIMEOUT)) begin
        mdl_mv <= 1'b0; mdl_err <= 1'b1; mdl_age <= 0;
      end else begin
        mdl_age <= mdl_age + 1; mdl_err <= 1'b0;
      end
    end else begin
      mdl_err <= 1'b0;
      mdl_age <= 0;
      mdl_wv  <= mdl_mv;
      mdl_wrd <= mdl_mrd;
      if (mdl_hazard()) begin
        mdl_mv <= 1'b0;
      end else begin
        mdl_mv    <= x_v && x_rd_v && (x_rd != 5'd0);
        mdl_mrd   <= x_rd;
        mdl_mload <= x_load;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_hazard_x", hazard_x, mdl_hazard());
      check("cyc_fwd_rs1", fwd_rs1, mdl_fwd(x_rs1_v, x_rs1));
      check("cyc_fwd_rs2", fwd_rs2, mdl_fwd(x_rs2_v, x_rs2));
      check("cyc_w_v", w_v, mdl_wv);
      if (mdl_wv) check("cyc_w_rd", w_rd, mdl_wrd);
      check("cyc_err_o", err_o, mdl_err);
    end
  end

  task automatic set_x(input logic v, input logic [4:0] rs1, input logic rs1v,
                       input logic [4:0] rs2, input logic rs2v,
                       input logic [4:0] rd, input logic rdv, input logic ld);
    x_v = v; x_rs1 = rs1; x_rs1_v = rs1v; x_rs2 = rs2; x_rs2_v = rs2v;
    x_rd = rd; x_rd_v = rdv; x_load = ld;
  endtask

  task automatic idle();
    set_x(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    mem_ack = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic flush();
    idle();
    repeat (3) nxt();
  endtask

  task automatic lw_x6();
    set_x(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
  endtask

  task automatic add_x5();
    set_x(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
  endtask

  task automatic add_x7_x5_x1();
    set_x(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
  endtask

  task automatic add_x9_indep();
    set_x(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);
  endtask

  initial begin
    idle();
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    nxt();
    neg();
    check("rst_hazard_x", hazard_x, 0);
    check("rst_fwd_rs1", fwd_rs1, 0);
    check("rst_fwd_rs2", fwd_rs2, 0);
    check("rst_w_v", w_v, 0);
    check("rst_err_o", err_o, 0);
    nxt();
    reset_n = 1'b1;
    nxt();

    // Reset while a load waits for its acknowledge.
    lw_x6();
    nxt();
    idle();
    neg();
    check("t1_stall_first", hazard_x, 1);
    nxt();
    neg();
    check("t1_stall_wait", hazard_x, 1);
    #1 reset_n = 1'b0;
    #1;
    check("t1_rst_hazard_x", hazard_x, 0);
    check("t1_rst_w_v", w_v, 0);
    check("t1_rst_err_o", err_o, 0);
    nxt();
    nxt();
    reset_n = 1'b1;
    neg();
    check("t1_post_err_o", err_o, 0);
    check("t1_post_hazard_x", hazard_x, 0);
    flush();

    // Back-to-back dependency.
    add_x5();
    nxt();
    add_x7_x5_x1();
    neg();
    check("t2_b2b_hazard_x", hazard_x, FWD ? 0 : 1);
    check("t2_b2b_fwd_rs1", fwd_rs1, FWD ? 2'b01 : 2'b00);
    flush();

    // Dependency with one gap.
    add_x5();
    nxt();
    idle();
    nxt();
    add_x7_x5_x1();
    neg();
    check("t2_gap_hazard_x", hazard_x, FWD ? 0 : 1);
    check("t2_gap_fwd_rs1", fwd_rs1, FWD ? 2'b10 : 2'b00);
    flush();

    // Consumer held in X right behind its producer: stall length.
    add_x5();
    nxt();
    add_x7_x5_x1();
    for (int i = 0; i < 3; i++) begin
      neg();
      check("t6_dep_hazard_x", hazard_x, (!FWD && i < 2) ? 1 : 0);
      nxt();
    end
    flush();

    // Load acked in its first M cycle, dependant right behind.
    lw_x6();
    nxt();
    set_x(1'b1, 5'd6, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
    mem_ack = 1'b1;
    neg();
    check("t3_lu_hazard_x", hazard_x, 1);
    check("t3_lu_fwd_rs1", fwd_rs1, 2'b00);
    nxt();
    mem_ack = 1'b0;
    neg();
    check("t3_hazard_x", hazard_x, FWD ? 0 : 1);
    check("t3_fwd_rs1", fwd_rs1, FWD ? 2'b10 : 2'b00);
    check("t3_fwd_rs2", fwd_rs2, FWD ? 2'b10 : 2'b00);
    check("t3_w_v", w_v, 1);
    check("t3_w_rd", w_rd, 6);
    nxt();
    neg();
    check("t3_released", hazard_x, 0);
    flush();

    // Load acked three cycles late; ack coincides with the last allowed wait cycle.
    lw_x6();
    nxt();
    add_x9_indep();
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      neg();
      check("t4_hazard_x", hazard_x, (i < 3) ? 1 : 0);
      nxt();
    end
    idle();
    neg();
    check("t4_w_v", w_v, 1);
    check("t4_w_rd", w_rd, 6);
    check("t4_no_err", err_o, 0);
    flush();

    // Load never acked: abort after TIMEOUT cycles in M.
    lw_x6();
    nxt();
    add_x9_indep();
    for (int i = 0; i < 4; i++) begin
      neg();
      check("t5_wait_hazard_x", hazard_x, 1);
      check("t5_wait_err_o", err_o, 0);
      nxt();
    end
    neg();
    check("t5_err_o", err_o, 1);
    check("t5_hazard_x", hazard_x, 0);
    check("t5_w_v", w_v, 0);
    nxt();
    idle();
    neg();
    check("t5_err_pulse", err_o, 0);
    check("t5_no_w_write", w_v, 0);
    flush();

    // x0 is never a destination.
    set_x(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    nxt();
    set_x(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    neg();
    check("t6_x0_hazard_x", hazard_x, 0);
    check("t6_x0_fwd_rs1", fwd_rs1, 2'b00);
    check("t6_x0_fwd_rs2", fwd_rs2, 2'b00);
    nxt();
    idle();
    neg();
    check("t6_x0_w_v", w_v, 0);
    flush();

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
